// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lets N byte streams share one UART transmitter.
// A granted requester owns the transmitter until its last byte transfers, then an optional idle gap follows.
module uart_tx_arbiter #(
  parameter int N   = 4,
  parameter int GAP = 2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req_valid,
  input  logic [8*N-1:0] req_byte,
  input  logic [N-1:0]   req_last,
  output logic [N-1:0]   req_ready,
  output logic           tx_valid,
  output logic [7:0]     tx_byte,
  input  logic           tx_ready,
  output logic [N-1:0]   grant,
  output logic           busy
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = IW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [7:0]    GAP_LOAD = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam logic [N-1:0]  ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [7:0]    gap_cnt_q, gap_cnt_d;
  logic [IW-1:0] pick_s;
  logic [SW-1:0] idx_s;
  logic          found_s;
  logic          xfer_s;

  // Round-robin search: first valid requester at or above ptr, wrapping past N-1.
  always_comb begin
    found_s = 1'b0;
    pick_s  = '0;
    idx_s   = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = {1'b0, ptr_q} + SW'(k);
      idx_s = (idx_s >= SW'(N)) ? (idx_s - SW'(N)) : idx_s;
      if (!found_s && req_valid[idx_s[IW-1:0]]) begin
        found_s = 1'b1;
        pick_s  = idx_s[IW-1:0];
      end else begin
        found_s = found_s;
      end
    end
  end

  // Owner pass-through; everything is quiet outside PASS.
  always_comb begin
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    req_ready = '0;
    if (state_q == ST_PASS) begin
      tx_valid           = req_valid[owner_q];
      tx_byte            = req_valid[owner_q] ? req_byte[8*owner_q +: 8] : 8'h00;
      req_ready[owner_q] = tx_ready;
    end else begin
      tx_valid = 1'b0;
    end
  end

  assign xfer_s = tx_valid & tx_ready;

  // Next-state logic for the IDLE / PASS / GAP sequencer.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          grant_d = ONE_HOT0 << pick_s;
          owner_d = pick_s;
          state_d = ST_PASS;
        end else begin
          grant_d = '0;
        end
      end
      ST_PASS: begin
        if (xfer_s && req_last[owner_q]) begin
          ptr_d   = (owner_q == LAST_IDX) ? '0 : (owner_q + IW'(1));
          grant_d = '0;
          if (GAP > 0) begin
            state_d   = ST_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_PASS;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 8'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State registers; reset overrides any transfer in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      gap_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, legal range 2..8.
REQ-002 SHALL have parameter GAP, default 2: idle clocks inserted after each packet, legal range 0..255.
REQ-003 SHALL have port clk, input, 1: sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: one clock; reset is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, N: per-requester byte valid.
REQ-006 SHALL have port req_byte, input, 8*N: requester i byte in bits [8*i+7:8*i].
REQ-007 SHALL have port req_last, input, N: marks the current byte as the end of the packet; sampled only when the byte transfers.
REQ-008 SHALL have port req_ready, output, N: per-requester accept strobe.
REQ-009 SHALL have port tx_valid, output, 1: drives the data_valid input of the shared UART transmitter.
REQ-010 SHALL have port tx_byte, output, 8: drives the data_byte input of the transmitter.
REQ-011 SHALL have port tx_ready, input, 1: from the data_ready output of the transmitter.
REQ-012 SHALL have port grant, output, N: one-hot current owner; all zero when no requester owns the transmitter.
REQ-013 SHALL have port busy, output, 1: high in states PASS and GAP.

Function
REQ-014 SHALL implement three states: IDLE, PASS and GAP.
REQ-015 In IDLE with any req_valid bit set, the block SHALL register the grant to the first set index found by searching upward from ptr, wrapping at N-1 back to 0, and SHALL enter PASS on the next clock.
REQ-016 In IDLE, tx_valid SHALL be 0 and req_ready SHALL be all zero, so a byte never transfers in the arbitration cycle; first-byte latency from req_valid is exactly 1 clock.
REQ-017 In PASS, with owner g, the block SHALL drive combinationally tx_valid = req_valid[g], tx_byte = req_byte[g], req_ready[g] = tx_ready, and req_ready = 0 for every other requester.
REQ-018 In PASS, a transfer SHALL occur exactly when tx_valid and tx_ready are both high in the same cycle.
REQ-019 When the owner deasserts req_valid mid-packet, the block SHALL hold the grant and remain in PASS indefinitely; there is no timeout.
REQ-020 A transfer with req_last[g] high SHALL set ptr to (g+1) mod N, clear grant, and move to GAP if GAP>0 or to IDLE if GAP=0.
REQ-021 GAP SHALL last exactly GAP clocks, counted by an 8-bit down-counter loaded with GAP-1, then move to IDLE.
REQ-022 In GAP, tx_valid and req_ready SHALL be 0 and new requests SHALL be ignored.
REQ-023 When tx_valid is 0, tx_byte SHALL be 0.
REQ-024 Requests on non-owner channels SHALL have no effect until the block returns to IDLE.
REQ-025 With GAP=0, the next packet SHALL start arbitration in the cycle after the last-byte transfer (one-cycle IDLE), giving round-robin fairness.
REQ-026 A single requester with continuous packets SHALL be re-granted after every IDLE cycle.

Reset
REQ-027 Reset SHALL set state to IDLE, ptr to 0, the gap counter to 0 and grant to 0; tx_valid, req_ready and busy SHALL read 0 from the first clock after reset is sampled high.
REQ-028 Reset asserted mid-packet SHALL abandon the packet without completing the byte, and SHALL take priority over a simultaneous transfer.
REQ-029 No output SHALL depend on reset combinationally.

Verification
REQ-030 Bench SHALL cover: reset, then req_valid=4'b0101 at the same time, each with a 2-byte packet (0xA1,0xA2 / 0xC1,0xC2), GAP=2, tx_ready always 1 -> grant=0001, bytes A1,A2, 2 idle clocks, then grant=0100, bytes C1,C2, ptr ends at 3.
REQ-031 Bench SHALL cover: all four requesters continuously valid, 1-byte packets, GAP=0 -> grant order 0,1,2,3,0 with one IDLE cycle between packets.
REQ-032 Bench SHALL cover: owner 1 drops req_valid for 5 clocks mid-packet while requester 2 is valid -> grant stays 0010, tx_valid=0 for those 5 clocks, and requester 2 sees no req_ready.
REQ-033 Bench SHALL cover: tx_ready held low for 100 clocks with owner valid and byte 0x55 -> tx_byte stable at 0x55, exactly one transfer when tx_ready rises, and no duplicate byte.
REQ-034 Bench SHALL cover: reset pulsed for 1 clock in PASS with the last byte pending -> the next clock shows grant=0, busy=0, ptr=0, and the requester retains its byte.
REQ-035 Bench SHALL cover: integration with uart_tx (CLK=51_800_000, BAUD=115200) using two requesters -> the serial line decodes the packets intact, in round-robin order, with no interleaved bytes.
